team_06_echo_delay_buffer: RTL

TEAM_06_ECHO_DELAY_BUFFER -- requirements
Module: team_06_echo_delay_buffer

---
 rtl/team_06_echo_delay_buffer_if.sv | 38 +++
 rtl/team_06_echo_delay_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_echo_delay_buffer_if.sv
// ---------------------------------------------------------------------------
// team_06_echo_delay_buffer_if
// Request/acknowledge bus between the echo delay buffer and its 8192 x 8
// delay memory.
//   mem_req   : request; held high until mem_ack is sampled high
//   mem_we    : 1 = write, 0 = read (meaningful only while mem_req = 1)
//   mem_addr  : 13-bit word address
//   mem_wdata : write data
//   mem_ack   : completion strobe from the memory, sampled on clk
//   mem_rdata : read data, valid in the cycle mem_ack is high on a read
// master = the buffer (issues requests), slave = the memory.
// ---------------------------------------------------------------------------
interface team_06_echo_delay_buffer_if;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/team_06_echo_delay_buffer.sv
// ---------------------------------------------------------------------------
// team_06_echo_delay_buffer
// Circular delay line for an audio echo effect. Every accepted sample is
// written to the next slot of an external 8192-entry memory; when the sample
// also asks for a search, the sample written `offset` samples earlier is
// read back and presented on past_output with a one-cycle past_valid pulse.
//
// Ports
//   clk          : rising-edge clock
//   rst          : asynchronous, active-high reset
//   sample_valid : one-cycle strobe for a new sample
//   save_audio   : sample to store (captured with sample_valid)
//   search       : request a past-sample read (captured with sample_valid)
//   offset       : delay in samples, 0..8191 (captured with sample_valid)
//   past_output  : most recent delayed sample
//   past_valid   : one-cycle pulse when past_output has been updated
//   busy         : high whenever a sample is being processed
//   overrun      : one-cycle pulse when a strobe arrives while busy
//   mem          : memory request bus (master side)
//
// Flow: IDLE -> WRITE -> (IDLE | READ -> DONE | DONE) -> IDLE.
// All outputs are registered; bus values are loaded on entry to a state and
// held until the corresponding ack, so they stay stable under slow memories.
// ---------------------------------------------------------------------------
module team_06_echo_delay_buffer (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_valid,
  input  logic [7:0]                         save_audio,
  input  logic                               search,
  input  logic [12:0]                        offset,
  output logic [7:0]                         past_output,
  output logic                               past_valid,
  output logic                               busy,
  output logic                               overrun,
  team_06_echo_delay_buffer_if.master        mem
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of memory slots; the write counter saturates here.
  localparam logic [13:0] WCOUNT_MAX = 14'd8192;

  // Saturating increment of the writes-since-reset counter.
  function automatic logic [13:0] wcount_inc(input logic [13:0] cnt);
    if (cnt >= WCOUNT_MAX) begin
      wcount_inc = WCOUNT_MAX;
    end else begin
      wcount_inc = cnt + 14'd1;
    end
  endfunction

  // Read address for a delay; 13-bit subtraction wraps modulo 8192, so an
  // offset of 0 addresses the slot that was just written.
  function automatic logic [12:0] past_addr(input logic [12:0] wa,
                                            input logic [12:0] off);
    past_addr = wa - off;
  endfunction

  // True while the requested delay reaches further back than the number of
  // samples written so far: the slot holds no real audio yet.
  function automatic logic is_cold(input logic [12:0] off,
                                   input logic [13:0] cnt);
    is_cold = ({1'b0, off} > cnt);
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;

  logic [7:0]  sample_r;
  logic        search_r;
  logic [12:0] offset_r;
  logic [12:0] wr_ptr_r;
  logic [13:0] wcount_r;

  logic        mem_req_r;
  logic        mem_we_r;
  logic [12:0] mem_addr_r;
  logic [7:0]  mem_wdata_r;

  logic [7:0]  past_output_r;
  logic        past_valid_r;
  logic        busy_r;
  logic        overrun_r;

  logic        accept_s;
  logic        drop_s;
  logic        wr_done_s;
  logic        rd_done_s;
  logic        cold_s;

  // Next-state decode and per-cycle event flags.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    wr_done_s   = 1'b0;
    rd_done_s   = 1'b0;
    cold_s      = 1'b0;
    // Any strobe outside IDLE (DONE included) is lost.
    drop_s      = sample_valid && (state_r != ST_IDLE);

    case (state_r)
      ST_IDLE: begin
        // A late ack from an aborted transaction is ignored here.
        if (sample_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem.mem_ack) begin
          wr_done_s = 1'b1;
          if (!search_r) begin
            state_nxt_s = ST_IDLE;
          end else if (is_cold(offset_r, wcount_r)) begin
            cold_s      = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (mem.mem_ack) begin
          rd_done_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Captured sample fields plus the circular write pointer and fill count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_r <= 8'd0;
      search_r <= 1'b0;
      offset_r <= 13'd0;
      wr_ptr_r <= 13'd0;
      wcount_r <= 14'd0;
    end else begin
      if (accept_s) begin
        sample_r <= save_audio;
        search_r <= search;
        offset_r <= offset;
      end
      if (wr_done_s) begin
        wr_ptr_r <= wr_ptr_r + 13'd1;
        wcount_r <= wcount_inc(wcount_r);
      end
    end
  end

  // Memory bus registers: loaded when WRITE or READ is entered, held until ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 13'd0;
      mem_wdata_r <= 8'd0;
    end else begin
      mem_req_r <= (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_READ);
      if (accept_s) begin
        mem_we_r    <= 1'b1;
        mem_addr_r  <= wr_ptr_r;
        mem_wdata_r <= save_audio;
      end else if (wr_done_s && (state_nxt_s == ST_READ)) begin
        // wr_ptr_r still holds the address just written at this point.
        mem_we_r   <= 1'b0;
        mem_addr_r <= past_addr(wr_ptr_r, offset_r);
      end
    end
  end

  // Status outputs and the returned past sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      past_output_r <= 8'd0;
      past_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      past_valid_r <= (state_nxt_s == ST_DONE);
      busy_r       <= (state_nxt_s != ST_IDLE);
      overrun_r    <= drop_s;
      if (cold_s) begin
        past_output_r <= 8'd0;
      end else if (rd_done_s) begin
        past_output_r <= mem.mem_rdata;
      end
    end
  end

  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;

  assign past_output = past_output_r;
  assign past_valid  = past_valid_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;

  // sample_r is the source of mem_wdata only through save_audio at accept;
  // it is kept so the captured sample is visible for debug.
  logic unused_s;
  assign unused_s = ^sample_r;

endmodule
